pipe_front_regs: RTL



---
 rtl/pipe_front_regs.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/pipe_front_regs.sv
// Fetch PC, IF/ID and ID/EX pipeline registers for the five-stage MIPS core,
// with hazard-driven stall/clear/flush handling and saturating stall/bubble counters.
module pipe_front_regs #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          CNT_W    = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stallF,
    input  logic             stallD,
    input  logic             flushE,
    input  logic             pcsrcD,
    input  logic             jumpD,
    input  logic             cnt_clr,
    input  logic [31:0]      pcnextF,
    input  logic [31:0]      instrF,
    input  logic [31:0]      pcplus4F,
    input  logic [31:0]      rd1D,
    input  logic [31:0]      rd2D,
    input  logic [31:0]      signimmD,
    input  logic [4:0]       rsD,
    input  logic [4:0]       rtD,
    input  logic [4:0]       rdD,
    input  logic [7:0]       ctrlD,
    output logic [31:0]      pcF,
    output logic [31:0]      instrD,
    output logic [31:0]      pcplus4D,
    output logic             validD,
    output logic [31:0]      srcaE,
    output logic [31:0]      srcbE,
    output logic [31:0]      signimmE,
    output logic [4:0]       rsE,
    output logic [4:0]       rtE,
    output logic [4:0]       rdE,
    output logic [7:0]       ctrlE,
    output logic             validE,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] bubble_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic        clr_d;
    logic [31:0] pc_q, pc_d;

    logic [31:0] if_instr_q, if_instr_d;
    logic [31:0] if_pcplus4_q, if_pcplus4_d;
    logic        if_valid_q, if_valid_d;

    logic [31:0] ex_srca_q, ex_srca_d;
    logic [31:0] ex_srcb_q, ex_srcb_d;
    logic [31:0] ex_imm_q, ex_imm_d;
    logic [4:0]  ex_rs_q, ex_rs_d;
    logic [4:0]  ex_rt_q, ex_rt_d;
    logic [4:0]  ex_rd_q, ex_rd_d;
    logic [7:0]  ex_ctrl_q, ex_ctrl_d;
    logic        ex_valid_q, ex_valid_d;

    logic [1:0]  cnt_inc;

    assign clr_d = pcsrcD | jumpD;

    always_comb begin
        pc_d = stallF ? pc_q : pcnextF;

        // A stalled branch may resolve pcsrcD from stale operands, so hold beats clear.
        if_instr_d   = if_instr_q;
        if_pcplus4_d = if_pcplus4_q;
        if_valid_d   = if_valid_q;
        if (!stallD) begin
            if (clr_d) begin
                if_instr_d   = 32'h0;
                if_pcplus4_d = 32'h0;
                if_valid_d   = 1'b0;
            end else begin
                if_instr_d   = instrF;
                if_pcplus4_d = pcplus4F;
                if_valid_d   = 1'b1;
            end
        end

        ex_srca_d  = rd1D;
        ex_srcb_d  = rd2D;
        ex_imm_d   = signimmD;
        ex_rs_d    = rsD;
        ex_rt_d    = rtD;
        ex_rd_d    = rdD;
        ex_ctrl_d  = ctrlD;
        ex_valid_d = if_valid_q;
        if (flushE) begin
            ex_srca_d  = 32'h0;
            ex_srcb_d  = 32'h0;
            ex_imm_d   = 32'h0;
            ex_rs_d    = 5'h0;
            ex_rt_d    = 5'h0;
            ex_rd_d    = 5'h0;
            ex_ctrl_d  = 8'h0;
            ex_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q         <= RESET_PC;
            if_instr_q   <= 32'h0;
            if_pcplus4_q <= 32'h0;
            if_valid_q   <= 1'b0;
            ex_srca_q    <= 32'h0;
            ex_srcb_q    <= 32'h0;
            ex_imm_q     <= 32'h0;
            ex_rs_q      <= 5'h0;
            ex_rt_q      <= 5'h0;
            ex_rd_q      <= 5'h0;
            ex_ctrl_q    <= 8'h0;
            ex_valid_q   <= 1'b0;
        end else begin
            pc_q         <= pc_d;
            if_instr_q   <= if_instr_d;
            if_pcplus4_q <= if_pcplus4_d;
            if_valid_q   <= if_valid_d;
            ex_srca_q    <= ex_srca_d;
            ex_srcb_q    <= ex_srcb_d;
            ex_imm_q     <= ex_imm_d;
            ex_rs_q      <= ex_rs_d;
            ex_rt_q      <= ex_rt_d;
            ex_rd_q      <= ex_rd_d;
            ex_ctrl_q    <= ex_ctrl_d;
            ex_valid_q   <= ex_valid_d;
        end
    end

    // Counter 0 tracks decode stalls; counter 1 counts cycles with any bubble (once per cycle).
    assign cnt_inc[0] = stallD;
    assign cnt_inc[1] = flushE | (clr_d & ~stallD);

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_cnt
            logic [CNT_W-1:0] cnt_q, cnt_d;

            always_comb begin
                cnt_d = cnt_q;
                if (cnt_clr)
                    cnt_d = '0;
                else if (cnt_inc[gi] && (cnt_q != CNT_MAX))
                    cnt_d = cnt_q + CNT_W'(1);
            end

            always_ff @(posedge clk) begin
                if (reset)
                    cnt_q <= '0;
                else
                    cnt_q <= cnt_d;
            end
        end
    endgenerate

    assign stall_cnt  = g_cnt[0].cnt_q;
    assign bubble_cnt = g_cnt[1].cnt_q;

    assign pcF      = pc_q;
    assign instrD   = if_instr_q;
    assign pcplus4D = if_pcplus4_q;
    assign validD   = if_valid_q;
    assign srcaE    = ex_srca_q;
    assign srcbE    = ex_srcb_q;
    assign signimmE = ex_imm_q;
    assign rsE      = ex_rs_q;
    assign rtE      = ex_rt_q;
    assign rdE      = ex_rd_q;
    assign ctrlE    = ex_ctrl_q;
    assign validE   = ex_valid_q;

endmodule
